glb_proc_arbiter: RTL

- Shares the single global-buffer processor packet port (proc_packet_wr_*/rd_*) among NUM_REQ host-side requesters (e.g. config loader, DMA kernel, debug reader).
- Round-robin arbitration grants at most one request per cycle and drives a registered packet onto the port.
- Issuer IDs of outstanding reads are tracked in an in-order FIFO, so each returning rd_data is routed to the requester that issued it.
- Sits between the host-side request agents and the Garnet top-level proc packet inputs.

---
 rtl/glb_proc_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/glb_proc_arbiter.sv
// Round-robin arbiter sharing the GLB processor packet port among NUM_REQ requesters,
// with an in-order issuer FIFO for read returns. Optional stall counters: GLB_PROC_ARB_PERF_EN.
module glb_proc_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 64,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_wr_en,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]        req_wr_strb,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wr_data,
    input  logic [NUM_REQ-1:0]                   req_rd_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_rd_addr,
    output logic [NUM_REQ-1:0]                   req_gnt,
    output logic [DATA_WIDTH-1:0]                req_rd_data,
    output logic [NUM_REQ-1:0]                   req_rd_data_valid,
    output logic                                 proc_packet_wr_en,
    output logic [STRB_WIDTH-1:0]                proc_packet_wr_strb,
    output logic [ADDR_WIDTH-1:0]                proc_packet_wr_addr,
    output logic [DATA_WIDTH-1:0]                proc_packet_wr_data,
    output logic                                 proc_packet_rd_en,
    output logic [ADDR_WIDTH-1:0]                proc_packet_rd_addr,
    input  logic [DATA_WIDTH-1:0]                proc_packet_rd_data,
    input  logic                                 proc_packet_rd_data_valid,
    output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]   rd_outstanding,
    output logic                                 err_unexpected_rd
`ifdef GLB_PROC_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]                perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_fifo [RD_FIFO_DEPTH];
    logic             r_err;

    logic                r_wr_en;
    logic [STRB_WIDTH-1:0] r_wr_strb;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic               w_pop;
    logic [IDX_W-1:0]   w_head;
    logic               w_rd_room;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_wr;
    logic               w_gnt_rd;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] w_rd_valid;

    assign w_pop  = w_rst_n & proc_packet_rd_data_valid & (r_count != '0);
    assign w_head = r_fifo[r_rd_ptr];

    // A return in this cycle frees a slot before the new read is pushed.
    assign w_rd_room = w_pop | (r_count != CNT_W'(RD_FIFO_DEPTH));
    assign w_elig    = req_wr_en | (req_rd_en & {NUM_REQ{w_rd_room}});

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (w_rst_n && !w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_found) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign req_gnt   = w_gnt;
    assign w_gnt_wr  = w_found & req_wr_en[w_gnt_idx];
    assign w_gnt_rd  = w_found & ~req_wr_en[w_gnt_idx];
    assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_strb <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            if (w_found) r_ptr <= w_ptr_nxt;
            r_wr_en <= w_gnt_wr;
            r_rd_en <= w_gnt_rd;
            if (w_gnt_wr) begin
                r_wr_strb <= req_wr_strb[w_gnt_idx*STRB_WIDTH +: STRB_WIDTH];
                r_wr_addr <= req_wr_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_wr_data <= req_wr_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_gnt_rd) begin
                r_rd_addr <= req_rd_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Issuer storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_gnt_rd) r_fifo[r_wr_ptr] <= w_gnt_idx;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_gnt_rd) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_gnt_rd, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (proc_packet_rd_data_valid && (r_count == '0)) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_rd_valid = '0;
        if (w_pop) w_rd_valid[w_head] = 1'b1;
    end

    assign req_rd_data_valid   = w_rd_valid;
    assign req_rd_data         = w_pop ? proc_packet_rd_data : '0;
    assign rd_outstanding      = r_count;
    assign err_unexpected_rd   = r_err;
    assign proc_packet_wr_en   = r_wr_en;
    assign proc_packet_wr_strb = r_wr_strb;
    assign proc_packet_wr_addr = r_wr_addr;
    assign proc_packet_wr_data = r_wr_data;
    assign proc_packet_rd_en   = r_rd_en;
    assign proc_packet_rd_addr = r_rd_addr;

`ifdef GLB_PROC_ARB_PERF_EN
    logic [NUM_REQ-1:0] w_active;
    logic [15:0]        r_stall [NUM_REQ];

    assign w_active = req_wr_en | req_rd_en;

    // Counts every waiting cycle, including reads held off by a full FIFO.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_stall[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_active[i] && !w_gnt[i] && (r_stall[i] != 16'hFFFF)) begin
                    r_stall[i] <= r_stall[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_stall_cnt[g*16 +: 16] = r_stall[g];
    end
`endif

endmodule
